// File: rtl/serdes_tx_sequencer.sv
// Bring-up and link controller for one 10:1 TMDS serializer lane: qualifies PLL lock,
// sequences serializer reset and training, then passes live parallel words through.
module serdes_tx_sequencer #(
   parameter int                        KPARALLELWIDTH     = 10,
   parameter int                        LOCK_STABLE_CYCLES = 1024,
   parameter int                        SER_RST_CYCLES     = 16,
   parameter int                        TRAIN_WORDS        = 64,
   parameter logic [KPARALLELWIDTH-1:0] TRAIN_PATTERN_A    = 10'b1101010100,
   parameter logic [KPARALLELWIDTH-1:0] TRAIN_PATTERN_B    = 10'b0010101011,
   parameter logic [KPARALLELWIDTH-1:0] IDLE_WORD          = 10'b1101010100
) (
   input  logic                      pixelclk,
   input  logic                      rstn,
   input  logic                      pll_lock,
   input  logic                      enable,
   input  logic                      retrain,
   input  logic [KPARALLELWIDTH-1:0] pdata_in,
   output logic                      data_ready,
   output logic [KPARALLELWIDTH-1:0] pdataout,
   output logic                      oser_rstn,
   output logic                      link_up,
   output logic [2:0]                state_o
);

   localparam int CNT_MAX_A = (LOCK_STABLE_CYCLES > SER_RST_CYCLES) ? LOCK_STABLE_CYCLES : SER_RST_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > TRAIN_WORDS) ? CNT_MAX_A : TRAIN_WORDS;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_SER_RST   = 3'd3,
      S_TRAIN     = 3'd4,
      S_RUN       = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic                      r_sync1;
   logic                      r_sync2;
   logic                      w_lock_s;
   logic [KPARALLELWIDTH-1:0] r_pdata;
   logic [KPARALLELWIDTH-1:0] w_pdata_nxt;
   logic                      r_oser_rstn;
   logic                      r_link_up;

   assign w_lock_s = r_sync2;

   // pll_lock is asynchronous to pixelclk; two flops before any decision uses it.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge pixelclk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_lock;
         r_sync2 <= r_sync1;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      case (r_state)
         S_IDLE:      w_state_nxt = enable ? S_WAIT_LOCK : S_IDLE;
         S_WAIT_LOCK: w_state_nxt = w_lock_s ? S_STABLE : S_WAIT_LOCK;
         S_STABLE: begin
            if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
               w_state_nxt = S_SER_RST;
            end else begin
               w_state_nxt = S_STABLE;
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_SER_RST: begin
            if (r_cnt == CNT_W'(SER_RST_CYCLES - 1)) begin
               w_state_nxt = S_TRAIN;
            end else begin
               w_state_nxt = S_SER_RST;
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_TRAIN: begin
            if (r_cnt == CNT_W'(TRAIN_WORDS - 1)) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_TRAIN;
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_RUN:       w_state_nxt = retrain ? S_TRAIN : S_RUN;
         default:     w_state_nxt = S_IDLE;
      endcase

      // Overrides in priority order: shutdown beats lock loss beats normal flow.
      if (!w_lock_s && (r_state inside {S_STABLE, S_SER_RST, S_TRAIN, S_RUN})) begin
         w_state_nxt = S_WAIT_LOCK;
         w_cnt_nxt   = '0;
      end
      if (!enable) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   always_comb begin
      w_pdata_nxt = IDLE_WORD;
      if (w_state_nxt == S_TRAIN) begin
         w_pdata_nxt = w_cnt_nxt[0] ? TRAIN_PATTERN_B : TRAIN_PATTERN_A;
      end else if ((w_state_nxt == S_RUN) && (r_state == S_RUN)) begin
         w_pdata_nxt = pdata_in;
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as r_state.
   always_ff @(posedge pixelclk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pdata     <= IDLE_WORD;
         r_oser_rstn <= 1'b0;
         r_link_up   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pdata     <= w_pdata_nxt;
         r_oser_rstn <= (w_state_nxt == S_TRAIN) || (w_state_nxt == S_RUN);
         r_link_up   <= (w_state_nxt == S_RUN);
      end
   end

   assign pdataout   = r_pdata;
   assign oser_rstn  = r_oser_rstn;
   assign link_up    = r_link_up;
   assign data_ready = r_link_up;
   assign state_o    = r_state;

endmodule

// File: tb/tb_serdes_tx_sequencer.sv
// Directed bench for serdes_tx_sequencer: phase/age reference model compared every cycle,
// plus literal edge-by-edge expectations for bring-up, glitch, lock loss, retrain and reset.
module tb_serdes_tx_sequencer;

   localparam int         W  = 10;
   localparam int         L  = 8;
   localparam int         S  = 4;
   localparam int         T  = 6;
   localparam logic [9:0] PA = 10'b1101010100;
   localparam logic [9:0] PB = 10'b0010101011;
   localparam logic [9:0] IW = 10'b1101010100;

   logic         pixelclk;
   logic         rstn;
   logic         pll_lock;
   logic         enable;
   logic         retrain;
   logic [W-1:0] pdata_in;
   logic         data_ready;
   logic [W-1:0] pdataout;
   logic         oser_rstn;
   logic         link_up;
   logic [2:0]   state_o;

   int n_pass  = 0;
   int n_total = 0;

   serdes_tx_sequencer #(
      .KPARALLELWIDTH    (W),
      .LOCK_STABLE_CYCLES(L),
      .SER_RST_CYCLES    (S),
      .TRAIN_WORDS       (T),
      .TRAIN_PATTERN_A   (PA),
      .TRAIN_PATTERN_B   (PB),
      .IDLE_WORD         (IW)
   ) dut (
      .pixelclk  (pixelclk),
      .rstn      (rstn),
      .pll_lock  (pll_lock),
      .enable    (enable),
      .retrain   (retrain),
      .pdata_in  (pdata_in),
      .data_ready(data_ready),
      .pdataout  (pdataout),
      .oser_rstn (oser_rstn),
      .link_up   (link_up),
      .state_o   (state_o)
   );

   initial pixelclk = 1'b0;
   always #5 pixelclk = ~pixelclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: phase = state code, age = cycles spent in the current phase.
   // Timed phases (STABLE, SER_RST, TRAIN) advance to the next phase code after their duration.
   int         m_phase;
   int         m_age;
   logic [1:0] m_pipe;   // pll_lock as seen 1 and 2 edges ago
   logic       m_hold;   // RUN on both sides of the last edge
   logic [9:0] m_pd;     // pdata_in sampled at the last edge

   function automatic int dur(input int ph);
      case (ph)
         2:       return L;
         3:       return S;
         default: return T;
      endcase
   endfunction

   function automatic int next_phase(input int ph, input int age, input logic ls,
                                     input logic en, input logic rt);
      if (!en)                return 0;
      if (!ls && ph >= 2)     return 1;
      case (ph)
         0:       return 1;
         1:       return ls ? 2 : 1;
         5:       return rt ? 4 : 5;
         default: return (age + 1 == dur(ph)) ? ph + 1 : ph;
      endcase
   endfunction

   always @(posedge pixelclk or negedge rstn) begin
      if (!rstn) begin
         m_phase <= 0;
         m_age   <= 0;
         m_pipe  <= 2'b00;
         m_hold  <= 1'b0;
         m_pd    <= '0;
      end else begin
         m_phase <= next_phase(m_phase, m_age, m_pipe[1], enable, retrain);
         m_age   <= (next_phase(m_phase, m_age, m_pipe[1], enable, retrain) == m_phase) ? m_age + 1 : 0;
         m_hold  <= (m_phase == 5) && (next_phase(m_phase, m_age, m_pipe[1], enable, retrain) == 5);
         m_pd    <= pdata_in;
         m_pipe  <= {m_pipe[0], pll_lock};
      end
   end

   always @(negedge pixelclk) begin
      check("cmp_state", 32'(state_o), 32'(m_phase));
      check("cmp_oser_rstn", 32'(oser_rstn), 32'(m_phase >= 4));
      check("cmp_link_up", 32'(link_up), 32'(m_phase == 5));
      check("cmp_data_ready", 32'(data_ready), 32'(m_phase == 5));
      if (m_phase == 4)      check("cmp_train_word", 32'(pdataout), 32'((m_age % 2 == 0) ? PA : PB));
      else if (m_phase == 5) begin
         if (m_hold)         check("cmp_run_word", 32'(pdataout), 32'(m_pd));
      end else               check("cmp_idle_word", 32'(pdataout), 32'(IW));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge pixelclk);
         #1;
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_pass=%0d n_total=%0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] run_vec [4];
      run_vec[0] = 10'h155;
      run_vec[1] = 10'h3FF;
      run_vec[2] = 10'h000;
      run_vec[3] = 10'h1C3;

      rstn = 1'b0; enable = 1'b1; pll_lock = 1'b1; retrain = 1'b0; pdata_in = '0;
      step(4);
      lit("rst_state", 32'(state_o), 32'd0);
      lit("rst_oser", 32'(oser_rstn), 32'd0);
      lit("rst_pdata", 32'(pdataout), 32'h354);
      lit("rst_link", 32'(link_up), 32'd0);

      // Bring-up: edges counted from reset release.
      rstn = 1'b1;
      step(1);  lit("e1_wait_lock", 32'(state_o), 32'd1);
      step(1);  lit("e2_still_wait", 32'(state_o), 32'd1);
      step(1);  lit("e3_stable", 32'(state_o), 32'd2);
      step(7);  lit("e10_stable", 32'(state_o), 32'd2);
      step(1);  lit("e11_ser_rst", 32'(state_o), 32'd3);
      lit("e11_oser_low", 32'(oser_rstn), 32'd0);
      step(3);  lit("e14_oser_low", 32'(oser_rstn), 32'd0);
      step(1);  lit("e15_oser_high", 32'(oser_rstn), 32'd1);
      lit("e15_state_train", 32'(state_o), 32'd4);
      lit("e15_word_a", 32'(pdataout), 32'(PA));
      for (int k = 1; k < 6; k++) begin
         step(1);
         lit("train_alt", 32'(pdataout), 32'(((k % 2) == 1) ? PB : PA));
      end
      step(1);  lit("e21_link_up", 32'(link_up), 32'd1);
      lit("e21_ready", 32'(data_ready), 32'd1);
      pdata_in = 10'h2AA;
      step(1);  lit("e22_pass_2aa", 32'(pdataout), 32'h2AA);
      for (int k = 0; k < 4; k++) begin
         pdata_in = run_vec[k];
         step(1);
         lit("run_pass", 32'(pdataout), 32'(run_vec[k]));
      end

      // Retrain from RUN, second pulse lands in TRAIN and must be ignored.
      retrain = 1'b1;
      step(1);  retrain = 1'b0;
      lit("rt_state_train", 32'(state_o), 32'd4);
      lit("rt_oser_kept", 32'(oser_rstn), 32'd1);
      lit("rt_ready_drop", 32'(data_ready), 32'd0);
      lit("rt_word_a", 32'(pdataout), 32'(PA));
      step(2);  retrain = 1'b1;
      step(1);  retrain = 1'b0;
      step(2);  lit("rt_r5_train", 32'(state_o), 32'd4);
      step(1);  lit("rt_r6_run", 32'(state_o), 32'd5);

      // Lock loss in RUN, then a clean full re-bring-up.
      pll_lock = 1'b0;
      step(2);  lit("ll_d2_still_run", 32'(state_o), 32'd5);
      step(1);  lit("ll_d3_wait", 32'(state_o), 32'd1);
      lit("ll_oser", 32'(oser_rstn), 32'd0);
      lit("ll_link", 32'(link_up), 32'd0);
      lit("ll_pdata", 32'(pdataout), 32'(IW));
      pll_lock = 1'b1;
      step(20); lit("rb_e20_train", 32'(state_o), 32'd4);
      step(1);  lit("rb_e21_run", 32'(state_o), 32'd5);

      // enable drop wins over simultaneous lock loss.
      enable = 1'b0; pll_lock = 1'b0;
      step(1);  lit("sim_idle", 32'(state_o), 32'd0);
      lit("sim_link", 32'(link_up), 32'd0);
      step(3);  pll_lock = 1'b1;
      step(3);

      // Re-enable with lock already synchronized, glitch during STABLE count 5.
      enable = 1'b1;
      step(1);  lit("gl_e1_wait", 32'(state_o), 32'd1);
      step(1);  lit("gl_e2_stable", 32'(state_o), 32'd2);
      step(5);  pll_lock = 1'b0;
      step(3);  pll_lock = 1'b1;
      lit("gl_e10_wait", 32'(state_o), 32'd1);
      step(2);  lit("gl_e12_wait", 32'(state_o), 32'd1);
      step(1);  lit("gl_e13_stable", 32'(state_o), 32'd2);
      step(7);  lit("gl_e20_stable", 32'(state_o), 32'd2);
      step(1);  lit("gl_e21_ser_rst", 32'(state_o), 32'd3);
      step(10); lit("gl_e31_run", 32'(state_o), 32'd5);

      // Asynchronous reset in the middle of TRAIN.
      retrain = 1'b1;
      step(1);  retrain = 1'b0;
      step(2);
      #2 rstn = 1'b0;
      #1;
      lit("ar_state", 32'(state_o), 32'd0);
      lit("ar_oser", 32'(oser_rstn), 32'd0);
      lit("ar_pdata", 32'(pdataout), 32'h354);
      lit("ar_link", 32'(link_up), 32'd0);
      lit("ar_ready", 32'(data_ready), 32'd0);
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serdes_tx_sequencer.md
Name: serdes_tx_sequencer

Overview:
Bring-up and link controller for one 10:1 output serializer lane in the HDMI/TMDS transmit path. It sits between pixel-domain video logic and the output serializer. It qualifies PLL lock and holds the serializer in reset until lock is stable. It then sends a deterministic training pattern and finally passes live parallel words through. It recovers automatically on lock loss and retrains on request.

Parameters:
KPARALLELWIDTH, 10, width of parallel word to serializer
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before serializer reset
SER_RST_CYCLES, 16, cycles serializer reset held asserted
TRAIN_WORDS, 64, number of training words emitted, >=2
TRAIN_PATTERN_A, 10'b1101010100, training word A, emitted on even index
TRAIN_PATTERN_B, 10'b0010101011, training word B, emitted on odd index
IDLE_WORD, 10'b1101010100, word driven when not training or running

Ports:
pixelclk  input  1  sole clock, parallel-word rate
rstn  input  1  asynchronous active-low reset
pll_lock  input  1  serial-clock PLL lock, asynchronous to pixelclk
enable  input  1  level; 1 = bring link up, 0 = shut down
retrain  input  1  single-cycle pulse; re-enter training from RUN
pdata_in  input  KPARALLELWIDTH  live word from encoder
data_ready  output  1  1 = pdata_in consumed this cycle
pdataout  output  KPARALLELWIDTH  word to serializer
oser_rstn  output  1  active-low reset to serializer
link_up  output  1  1 in RUN
state_o  output  3  current state encoding, debug

Behaviour:
- All outputs are registered.
- Reset values: oser_rstn=0, pdataout=IDLE_WORD, data_ready=0, link_up=0, state_o=0. The state machine resets to IDLE, counters reset to 0, and the sync flops reset to 0.
- pll_lock passes through a 2-flop synchronizer, giving lock_s. lock_s lags pll_lock by 2 edges.
- State encoding: IDLE=0, WAIT_LOCK=1, STABLE=2, SER_RST=3, TRAIN=4, RUN=5. Codes 6 and 7 go to IDLE.
- Transition priority, evaluated each edge:
  1. enable=0 in any state -> IDLE.
  2. lock_s=0 in any state other than IDLE or WAIT_LOCK -> WAIT_LOCK.
  3. Normal transitions below.
- IDLE: enable=1 -> WAIT_LOCK.
- WAIT_LOCK: lock_s=1 -> STABLE; counter cleared.
- STABLE: counter increments each cycle. At count LOCK_STABLE_CYCLES-1 -> SER_RST, counter cleared. STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
- SER_RST: lasts exactly SER_RST_CYCLES cycles -> TRAIN; counter and word index cleared.
- TRAIN: pdataout = TRAIN_PATTERN_A when index is even, TRAIN_PATTERN_B when odd. Emission starts with A on the first TRAIN cycle. After TRAIN_WORDS words -> RUN.
- RUN: data_ready=1 and link_up=1. On each edge where the state is RUN and remains RUN, pdataout <= pdata_in, so latency is 1 cycle. A retrain pulse -> TRAIN with index 0 and no serializer reset; data_ready drops on the same edge.
- retrain is ignored outside RUN.
- oser_rstn: 0 in IDLE, WAIT_LOCK, STABLE and SER_RST; 1 in TRAIN and RUN. It updates on the same edge as the state.
- pdataout is IDLE_WORD in every state except TRAIN and RUN.
- data_ready and link_up are 1 only in RUN.
- Counter width: $clog2 of max(LOCK_STABLE_CYCLES, SER_RST_CYCLES, TRAIN_WORDS)+1. The counter never wraps; it clears on every state change.
- Lock loss in STABLE, SER_RST, TRAIN or RUN: on the next edge the state is WAIT_LOCK, oser_rstn=0, pdataout=IDLE_WORD, and link_up and data_ready are 0. A full re-qualification is required afterwards.
- A lock glitch of 1 cycle at pll_lock may be missed by the synchronizer. Any glitch seen at lock_s restarts STABLE counting from WAIT_LOCK.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.

Test Plan:
- Reset: hold rstn=0 with enable=1 and pll_lock=1 -> oser_rstn=0, pdataout=10'h354, link_up=0, state_o=0 throughout.
- Bring-up (LOCK_STABLE_CYCLES=8, SER_RST_CYCLES=4, TRAIN_WORDS=6), enable=1 and pll_lock=1 from reset release:
  - WAIT_LOCK at edge 1, STABLE at edge 3.
  - SER_RST at edge 11; oser_rstn rises at edge 15.
  - pdataout shows A,B,A,B,A,B over edges 15-20.
  - link_up=1 at edge 21.
  - pdata_in=10'h2AA at edge 21 -> pdataout=10'h2AA after edge 22.
- Lock glitch: pll_lock low for 3 cycles during STABLE count 5 -> state returns to WAIT_LOCK, then a full 8 STABLE cycles before SER_RST.
- Lock loss in RUN: drop pll_lock -> state_o=1, oser_rstn=0, link_up=0, pdataout=IDLE_WORD 3 edges after the drop. Re-bring-up repeats the full sequence.
- Retrain in RUN: pulse retrain -> next edge state_o=4, oser_rstn stays 1, 6 training words, then RUN; ignore a retrain pulse during TRAIN.
- Simultaneous: enable=0 and pll_lock drop on the same cycle in RUN -> IDLE (state_o=0), not WAIT_LOCK. Asserting rstn low mid-TRAIN -> immediate reset values.
